// File: rtl/bcd_nines_tens_complementer_if.sv
// Handshake bundle for the BCD complementer: operand request channel and result channel.
// The design drives the slave modport; the producer/consumer side uses master.
interface bcd_nines_tens_complementer_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic                  out_carry;
  logic                  out_err;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

// File: rtl/bcd_nines_tens_complementer.sv
// Digit-serial BCD nine's/ten's complementer: one digit per clock, LSD first,
// with a complement carry-out and a sticky invalid-digit flag.
module bcd_nines_tens_complementer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  bcd_nines_tens_complementer_if.slave    bus
);
  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     operand_q, operand_d;
  logic [W-1:0]     data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             ocarry_q, ocarry_d;

  logic [3:0]       digit;
  logic [4:0]       t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      operand_q <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
      ocarry_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
      ocarry_q  <= ocarry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    data_d    = data_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    err_d     = err_q;
    ocarry_d  = ocarry_q;
    digit     = operand_q[{idx_q, 2'b00} +: 4];
    // 9-d never underflows for a valid digit, so t is at most 10.
    t         = 5'd9 - {1'b0, digit} + {4'b0000, carry_q};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          operand_d = bus.in_data;
          carry_d   = bus.in_mode;
          idx_d     = '0;
          err_d     = 1'b0;
          data_d    = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (digit > 4'd9) begin
          data_d[{idx_q, 2'b00} +: 4] = 4'd0;
          carry_d                     = 1'b0;
          err_d                       = 1'b1;
        end else if (t == 5'd10) begin
          data_d[{idx_q, 2'b00} +: 4] = 4'd0;
          carry_d                     = 1'b1;
        end else begin
          data_d[{idx_q, 2'b00} +: 4] = t[3:0];
          carry_d                     = 1'b0;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          ocarry_d = carry_d;
          idx_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_carry = ocarry_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_bcd_nines_tens_complementer.sv
// Randomised and directed bench for the BCD complementer against a decimal reference model.
module tb_bcd_nines_tens_complementer;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bcd_nines_tens_complementer_if #(.DIGITS(DIGITS)) bus ();

  bcd_nines_tens_complementer #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         carry;
    logic         err;
  } result_t;

  // Decimal complement, digit by digit with ordinary base-10 arithmetic.
  function automatic result_t model(input logic [W-1:0] op, input logic mode);
    result_t r;
    int unsigned c;
    int unsigned d;
    int unsigned s;
    r = '0;
    c = mode ? 1 : 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = (op >> (4 * i)) & 15;
      if (d > 9) begin
        r.err = 1'b1;
        c     = 0;
      end else begin
        s = (9 - d) + c;
        r.data = r.data | (W'(s % 10) << (4 * i));
        c = s / 10;
      end
    end
    r.carry = (c != 0);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand(input int unsigned bad_pct);
    logic [W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ($urandom_range(99) < bad_pct) v[4*i +: 4] = 4'($urandom_range(15, 10));
      else                              v[4*i +: 4] = 4'($urandom_range(9, 0));
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold_cycles > 0 keeps out_ready low in DONE for that long.
  task automatic run_op(input string name, input logic [W-1:0] op, input logic mode,
                        input int unsigned hold_cycles);
    result_t exp;
    int unsigned k;
    logic [W-1:0] held;
    exp = model(op, mode);
    bus.in_valid  = 1'b1;
    bus.in_data   = op;
    bus.in_mode   = mode;
    bus.out_ready = (hold_cycles == 0);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_mode  = 1'($urandom);
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
      bus.in_data = W'($urandom);
    end
    n_checks++;
    if (k != DIGITS) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges want %0d", name, k, DIGITS);
    end
    n_checks++;
    if (bus.out_data !== exp.data || bus.out_carry !== exp.carry || bus.out_err !== exp.err) begin
      n_fail++;
      $display("FAIL %s result: got data=%h carry=%b err=%b want data=%h carry=%b err=%b",
               name, bus.out_data, bus.out_carry, bus.out_err, exp.data, exp.carry, exp.err);
    end
    held = bus.out_data;
    for (int unsigned i = 0; i < hold_cycles; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== held) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: got valid=%b ready=%b data=%h want 1 0 %h",
                 name, i, bus.out_valid, bus.in_ready, bus.out_data, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after transfer: got valid=%b ready=%b want 0 1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_carry !== 1'b0 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset values: got ready=%b valid=%b data=%h carry=%b err=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_carry, bus.out_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op("nine_1234", 16'h1234, 1'b0, 0);
    run_op("ten_1234",  16'h1234, 1'b1, 0);
    run_op("ten_0990",  16'h0990, 1'b1, 0);
    run_op("ten_zero",  16'h0000, 1'b1, 0);
    run_op("nine_zero", 16'h0000, 1'b0, 0);
    run_op("nine_9999", 16'h9999, 1'b0, 0);
    run_op("err_12A4",  16'h12A4, 1'b0, 0);
    run_op("after_err", 16'h0001, 1'b0, 0);
    run_op("ten_err_F0", 16'h00F0, 1'b1, 0);
  endtask

  task automatic test_hold();
    run_op("hold_5678", 16'h5678, 1'b1, 10);
  endtask

  task automatic test_reset_mid_run();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    bus.in_mode  = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0 ||
        bus.out_carry !== 1'b0 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got valid=%b ready=%b data=%h carry=%b err=%b want 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.out_data, bus.out_carry, bus.out_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_reset", 16'h4321, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] op;
    for (int unsigned n = 0; n < 40; n++) begin
      op = rand_operand(15);
      run_op("random", op, 1'($urandom), $urandom_range(3) == 0 ? $urandom_range(4, 1) : 0);
    end
  endtask

  // in_valid and out_ready held high: accepts must be DIGITS+2 cycles apart.
  task automatic test_back_to_back();
    result_t exp_q[$];
    result_t exp;
    logic [W-1:0] op;
    logic mode;
    int unsigned sent;
    int unsigned got;
    int unsigned cyc;
    int unsigned last_acc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    last_acc = 0;
    bus.out_ready = 1'b1;
    while (got < 6 && cyc < 200) begin
      if (bus.out_valid === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.out_data !== exp.data || bus.out_carry !== exp.carry || bus.out_err !== exp.err) begin
          n_fail++;
          $display("FAIL b2b result %0d: got data=%h carry=%b err=%b want data=%h carry=%b err=%b",
                   got, bus.out_data, bus.out_carry, bus.out_err, exp.data, exp.carry, exp.err);
        end
        got++;
      end
      if (bus.in_ready === 1'b1 && sent < 6) begin
        op   = rand_operand(10);
        mode = 1'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = op;
        bus.in_mode  = mode;
        exp_q.push_back(model(op, mode));
        if (sent > 0) begin
          n_checks++;
          if (cyc - last_acc != DIGITS + 2) begin
            n_fail++;
            $display("FAIL b2b interval: got %0d cycles want %0d", cyc - last_acc, DIGITS + 2);
          end
        end
        last_acc = cyc;
        sent++;
      end else if (sent >= 6) begin
        bus.in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL b2b completion: got %0d results want 6", got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_nines_tens_complementer.md
Name: bcd_nines_tens_complementer

Overview:
- Parametrised, digit-serial successor to the single-digit BCD nine's-complement converter.
- Accepts a DIGITS-wide packed BCD operand through a valid/ready handshake.
- Computes its nine's complement (MODE=0) or ten's complement (MODE=1), processing one digit per clock, least significant digit first.
- Returns the result, a complement carry-out and a sticky invalid-digit error through a second valid/ready handshake. Sits between BCD keypad/register logic and the BCD adder/subtractor datapath.

Parameters:
- DIGITS, 4: number of BCD digits per operand; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand and mode are presented.
- in_ready  output  1  block can accept an operand.
- in_data  input  4*DIGITS  packed BCD operand; digit i = in_data[4i+3:4i], digit 0 is least significant.
- in_mode  input  1  0 = nine's complement, 1 = ten's complement.
- out_valid  output  1  result is held on out_data, out_carry and out_err.
- out_ready  input  1  downstream accepts the result.
- out_data  output  4*DIGITS  packed BCD result.
- out_carry  output  1  ten's-complement carry out of the most significant digit; always 0 in nine's mode.
- out_err  output  1  one or more operand digits were greater than 9.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_carry=0, out_err=0.
  - Internal digit index, carry and operand register all clear.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at a clock edge:
    - latch in_data and in_mode;
    - set carry = in_mode (1 for ten's complement);
    - clear the digit index, out_err and out_data;
    - go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes digit idx with d = operand digit idx:
    - Valid digit (d <= 9): t = (9 - d) + carry, computed 5 bits wide.
      - If t == 10: result digit = 0, carry = 1.
      - Otherwise: result digit = t[3:0], carry = 0.
    - Invalid digit (d > 9): result digit = 0, carry = 0, out_err set (sticky until the next accept).
  - idx increments after each digit.
  - After digit DIGITS-1: out_carry = final carry, go to DONE.
- DONE:
  - out_valid=1.
  - out_data, out_carry and out_err stay stable until out_valid && out_ready.
  - On that edge: out_valid=0, go to IDLE. in_ready is 1 from the next cycle.
  - No accept occurs in the same cycle as the output transfer.
- Latency: out_valid rises DIGITS clock edges after the accepting edge. Throughput is one operand per DIGITS+2 cycles when out_ready is held high.
- in_data and in_mode are ignored outside the IDLE accept edge. Changing them during RUN has no effect.
- out_ready held low in DONE: the result is held indefinitely and no new operand is accepted.
- Nine's mode: carry starts at 0 and never sets, so out_carry=0.
- Ten's complement of zero: all result digits are 0 and out_carry=1.
- DIGITS=1: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: immediately returns to the reset values and IDLE. The partial result is discarded.

Test Plan:
- Reset, then with DIGITS=4 send in_data=16'h1234, in_mode=0, out_ready=1 -> out_valid exactly 4 edges after accept, out_data=16'h8765, out_carry=0, out_err=0.
- Send 16'h1234 with in_mode=1 -> out_data=16'h8766, out_carry=0. Send 16'h0990 with in_mode=1 -> out_data=16'h9010.
- Send 16'h0000 with in_mode=1 -> out_data=16'h0000, out_carry=1. Send 16'h0000 with in_mode=0 -> out_data=16'h9999, out_carry=0.
- Send 16'h12A4 with in_mode=0 -> out_err=1, out_data=16'h8705. The next operand, 16'h0001 in mode 0, yields out_err=0 and out_data=16'h9998.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data and in_ready=0 all stay stable. Assert out_ready -> transfer on that edge, in_ready=1 on the next cycle.
- Deassert rst_n two cycles into RUN -> out_valid=0, in_ready=1 and outputs zeroed immediately (asynchronously). After release, a fresh operand completes correctly.
